// File: rtl/alu_sequencer.sv
// Operation sequencer for the calculator datapath: drives an external N-bit adder for
// ADD/SUB in one cycle and MUL by N iterations of shift-and-add, registering a 2N-bit result.
module alu_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [N-1:0]   opa,
    input  logic [N-1:0]   opb,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result,
    output logic           overflow,
    output logic [N-1:0]   add_a,
    output logic [N-1:0]   add_b,
    output logic           add_cin,
    input  logic [N-1:0]   add_sum
);

    localparam int unsigned CntW = $clog2(N) + 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [N-1:0]      m_q, m_d;
    logic [N-1:0]      p_hi_q, p_hi_d;
    logic [N-1:0]      p_lo_q, p_lo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]    result_q, result_d;
    logic              overflow_q, overflow_d;

    logic              cout;
    logic [N-1:0]      mul_hi, mul_lo;

    // Adder drive; p_lo_q doubles as the B operand register for ADD/SUB.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        unique case (state_q)
            StExec: begin
                add_a   = m_q;
                add_b   = (op_q == OpSub) ? ~p_lo_q : p_lo_q;
                add_cin = (op_q == OpSub);
            end
            StMul: begin
                add_a = p_hi_q;
                add_b = p_lo_q[0] ? m_q : '0;
            end
            default: ;
        endcase
    end

    // The adder exposes no carry, so recover it from the operand and sum MSBs.
    assign cout = (add_a[N-1] & add_b[N-1]) | ((add_a[N-1] ^ add_b[N-1]) & ~add_sum[N-1]);

    assign mul_hi = {cout, add_sum[N-1:1]};
    assign mul_lo = {add_sum[0], p_lo_q[N-1:1]};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        m_d        = m_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    op_d   = op;
                    m_d    = opa;
                    p_lo_d = opb;
                    p_hi_d = '0;
                    cnt_d  = '0;
                    if (op == OpAdd || op == OpSub) begin
                        state_d = StExec;
                    end else if (op == OpMul) begin
                        state_d = StMul;
                    end else begin
                        state_d    = StDone;
                        result_d   = '0;
                        overflow_d = 1'b1;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                if (op_q == OpSub) begin
                    result_d   = {{N{~cout}}, add_sum};
                    overflow_d = ~cout;
                end else begin
                    result_d   = {{(N-1){1'b0}}, cout, add_sum};
                    overflow_d = cout;
                end
                state_d = StDone;
            end
            StMul: begin
                p_hi_d = mul_hi;
                p_lo_d = mul_lo;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    result_d   = {mul_hi, mul_lo};
                    overflow_d = |mul_hi;
                    state_d    = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            m_q        <= '0;
            p_hi_q     <= '0;
            p_lo_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            m_q        <= m_d;
            p_hi_q     <= p_hi_d;
            p_lo_q     <= p_lo_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == StExec) || (state_q == StMul);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural adder and an arithmetic
// reference model; table vectors, multi-cycle corner sequences and random operations.
module tb_alu_sequencer;

    localparam int unsigned N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   opa, opb;
    logic           busy, done, overflow;
    logic [2*N-1:0] result;
    logic [N-1:0]   add_a, add_b, add_sum;
    logic           add_cin;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum)
    );

    // Behavioural stand-in for the carry-lookahead adder (carry-out discarded).
    assign add_sum = add_a + add_b + {{(N-1){1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] r;
        logic        ovf;
        int          busy_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic ref_calc(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                            output logic [15:0] r, output logic ovf, output int bc);
        int x;
        case (o)
            2'd0: begin x = int'(a) + int'(b); r = x[15:0]; ovf = (x > 255); bc = 1; end
            2'd1: begin x = int'(a) - int'(b); r = x[15:0]; ovf = (a < b);   bc = 1; end
            2'd2: begin x = int'(a) * int'(b); r = x[15:0]; ovf = (x > 255); bc = 8; end
            default: begin r = 16'h0; ovf = 1'b1; bc = 0; end
        endcase
    endtask

    // Issue one operation from idle; returns at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] r, output logic ovf, output int bc,
                          output logic seen);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        r = result;
        ovf = overflow;
    endtask

    logic [15:0] got_r, exp_r, prev_r;
    logic        got_o, exp_o, seen, stable;
    int          got_bc, exp_bc, k, dones, last_cyc;
    logic [1:0]  b2b_op[3];
    logic [7:0]  b2b_a[3], b2b_b[3];

    initial begin
        vecs[0] = '{2'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1};
        vecs[1] = '{2'd0, 8'd3,   8'd4,   16'h0007, 1'b0, 1};
        vecs[2] = '{2'd1, 8'd5,   8'd7,   16'hFFFE, 1'b1, 1};
        vecs[3] = '{2'd1, 8'd200, 8'd55,  16'h0091, 1'b0, 1};
        vecs[4] = '{2'd2, 8'd255, 8'd255, 16'hFE01, 1'b1, 8};
        vecs[5] = '{2'd2, 8'd12,  8'd11,  16'h0084, 1'b0, 8};
        vecs[6] = '{2'd2, 8'd0,   8'd77,  16'h0000, 1'b0, 8};
        vecs[7] = '{2'd2, 8'd99,  8'd77,  16'h1DC7, 1'b1, 8};
        vecs[8] = '{2'd3, 8'd9,   8'd9,   16'h0000, 1'b1, 0};
        vecs[9] = '{2'd1, 8'd7,   8'd7,   16'h0000, 1'b0, 1};

        reset = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        check("reset_result", 32'(result), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("idle_adder_drive", {15'h0, add_a, add_b, add_cin}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, got_r, got_o, got_bc, seen);
            check($sformatf("vec%0d_done", i), 32'(seen), 32'h1);
            check($sformatf("vec%0d_result", i), 32'(got_r), 32'(vecs[i].r));
            check($sformatf("vec%0d_overflow", i), 32'(got_o), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_busy_cycles", i), 32'(got_bc), 32'(vecs[i].busy_cyc));
        end
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'h0);

        // start pulsed mid-MUL must be ignored and result must hold until completion
        @(negedge clk);
        prev_r = result;
        start = 1'b1; op = 2'd2; opa = 8'd13; opb = 8'd17;
        @(negedge clk);
        start = 1'b0;
        stable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin seen = 1'b1; break; end
            if (result !== prev_r) stable = 1'b0;
            if (i == 2) begin start = 1'b1; op = 2'd0; opa = 8'd1; opb = 8'd1; end
            else start = 1'b0;
            @(negedge clk);
        end
        check("mul_ignore_done", 32'(seen), 32'h1);
        check("mul_result_hidden", 32'(stable), 32'h1);
        check("mul_ignore_result", 32'(result), 32'd221);
        @(negedge clk);
        check("mul_ignore_no_extra_busy", 32'(busy), 32'h0);
        check("mul_ignore_no_extra_done", 32'(done), 32'h0);

        // reset in the middle of a multiply
        start = 1'b1; op = 2'd2; opa = 8'd99; opb = 8'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_state", {28'h0, busy, done, overflow, 1'b0}, 32'h0);
        check("midreset_result", 32'(result), 32'h0);
        reset = 1'b0;
        run_op(2'd2, 8'd99, 8'd77, got_r, got_o, got_bc, seen);
        check("after_reset_mul", 32'(got_r), 32'h1DC7);

        // back-to-back: ADD, SUB accepted in done cycle, then reserved op
        @(negedge clk);
        b2b_op[0] = 2'd0; b2b_a[0] = 8'd10; b2b_b[0] = 8'd20;
        b2b_op[1] = 2'd1; b2b_a[1] = 8'd3;  b2b_b[1] = 8'd9;
        b2b_op[2] = 2'd3; b2b_a[2] = 8'd1;  b2b_b[2] = 8'd2;
        k = 0; dones = 0; last_cyc = -1;
        start = 1'b1; op = b2b_op[0]; opa = b2b_a[0]; opb = b2b_b[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                ref_calc(b2b_op[k], b2b_a[k], b2b_b[k], exp_r, exp_o, exp_bc);
                check($sformatf("b2b%0d_result", k), 32'(result), 32'(exp_r));
                check($sformatf("b2b%0d_overflow", k), 32'(overflow), 32'(exp_o));
                k++;
                if (k < 3) begin
                    start = 1'b1; op = b2b_op[k]; opa = b2b_a[k]; opb = b2b_b[k];
                end else begin
                    start = 1'b0;
                    last_cyc = cyc;
                    break;
                end
            end else begin
                start = 1'b0;
            end
        end
        check("b2b_done_count", 32'(dones), 32'd3);
        check("b2b_no_bubble", 32'(last_cyc), 32'd4);
        @(negedge clk);
        check("b2b_done_drops", 32'(done), 32'h0);

        // randomized operations against the reference model
        for (int i = 0; i < 1000; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = 8'($urandom);
            ref_calc(ro, ra, rb, exp_r, exp_o, exp_bc);
            run_op(ro, ra, rb, got_r, got_o, got_bc, seen);
            check($sformatf("rnd%0d_done op=%0d a=%0d b=%0d", i, ro, ra, rb), 32'(seen), 32'h1);
            check($sformatf("rnd%0d_result op=%0d a=%0d b=%0d", i, ro, ra, rb),
                  32'(got_r), 32'(exp_r));
            check($sformatf("rnd%0d_overflow", i), 32'(got_o), 32'(exp_o));
            check($sformatf("rnd%0d_busy_cycles", i), 32'(got_bc), 32'(exp_bc));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operation sequencer for the calculator datapath. It sits directly upstream of the N-bit carry-lookahead adder: it drives the adder's `A`, `B` and `cin` inputs and consumes its `Sum` output. It accepts one operation at a time (add, subtract or multiply) and registers a 2N-bit result with an overflow flag. Multiplication is done by iterated shift-and-add through the same adder, one partial product per clock.

## Interface
- `N`, default 8, is the operand width. It must match the adder's `N` and be at least 2.

Ports:
- `clk` in 1: the only clock. Everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request an operation. It is sampled only in IDLE or DONE.
- `op` in 2: operation select. 00 = ADD, 01 = SUB, 10 = MUL, 11 = reserved.
- `opa` in N, `opb` in N: unsigned operands, sampled with `start`.
- `busy` out 1: high while in the EXEC or MUL state.
- `done` out 1: one-cycle pulse marking that `result` and `overflow` have just updated.
- `result` out 2N: registered result.
- `overflow` out 1: registered flag.
- `add_a` out N, `add_b` out N, `add_cin` out 1: combinational drive into the adder.
- `add_sum` in N: the adder's Sum, used combinationally in the same cycle.

## Operation
- States are IDLE, EXEC, MUL and DONE. Reset forces IDLE, `result` = 0, `overflow` = 0, `done` = 0, `busy` = 0, and clears all internal registers.
- Accept: `start` = 1 in IDLE or DONE latches `op`, `opa` and `opb` into internal registers.
  - ADD or SUB goes to EXEC.
  - MUL goes to MUL and clears the iteration count.
  - op 11 goes straight to DONE with `result` = 0 and `overflow` = 1.
- In DONE without `start`, the block returns to IDLE. `start` during EXEC or MUL is ignored.
- The adder has no carry output. Carry is reconstructed from the MSB: `cout` = (a[N-1] & b[N-1]) | ((a[N-1] ^ b[N-1]) & ~add_sum[N-1]).
- ADD (EXEC): `add_a` = A, `add_b` = B, `add_cin` = 0.
  - `result` = {(N-1) zeros, `cout`, `add_sum`}.
  - `overflow` = `cout`, meaning the sum exceeded N bits.
- SUB (EXEC): `add_a` = A, `add_b` = ~B, `add_cin` = 1. The borrow is `borrow` = ~`cout`.
  - `result[N-1:0]` = `add_sum`; `result[2N-1:N]` = all ones if `borrow`, else zero. This gives the two's-complement value of A−B in 2N bits.
  - `overflow` = `borrow`, meaning A < B.
- MUL: internal registers are P_hi (N bits, cleared at accept), P_lo (N bits, loaded with B) and M (loaded with A).
  - Each MUL cycle: `add_a` = P_hi, `add_b` = P_lo[0] ? M : 0, `add_cin` = 0.
  - Then {P_hi, P_lo} ← {`cout`, `add_sum`, P_lo[N-1:1]} and the count increments.
  - After the N-th iteration, `result` = {P_hi, P_lo}, `overflow` = (P_hi != 0), and the state goes to DONE.
- Output drive:
  - In IDLE and DONE, `add_a`, `add_b` and `add_cin` are all 0.
  - `result` and `overflow` change only on the completion edge. They hold until the next operation completes or `reset` is asserted.
  - Intermediate MUL values are never visible on `result`.

## Timing
- Call the edge that samples `start` E0.
- ADD/SUB: result is written at E1. `done` = 1 and `busy` = 0 for the cycle after E1.
- MUL: iterations run on E1..EN and the result is written at EN. `done` = 1 for the cycle after EN.
- `busy` = 1 from the cycle after E0 through the cycle containing the final compute edge.
- Reserved op: `done` = 1 in the cycle after E0. `busy` never rises.
- Back-to-back: `start` may be presented during the `done` cycle and is accepted at that edge, with no idle bubble. `done` then drops.
- The adder path is single-cycle combinational. The timing path is operand register → adder → carry reconstruction → result/P registers.
- `reset` overrides everything at its edge, including mid-MUL. The iteration count, P registers and outputs clear. The first accept is possible on the edge after `reset` is released.

## Test plan
- N=8, ADD 200+100 → after E1: `done` pulse, `result` = 0x012C, `overflow` = 1. Then ADD 3+4 → `result` = 0x0007, `overflow` = 0.
- SUB 5−7 → `result` = 0xFFFE, `overflow` = 1. SUB 200−55 → `result` = 0x0091, `overflow` = 0.
- MUL 255×255 → `busy` for exactly 8 cycles, `done` after E8, `result` = 0xFE01, `overflow` = 1. MUL 12×11 → `result` = 0x0084, `overflow` = 0. MUL 0×N → `result` = 0.
- During a MUL, pulse `start` with ADD 1+1 at iteration 3 → ignored. The MUL result is correct, and `result` is unchanged until E8.
- Assert `reset` at iteration 4 of MUL 99×77 → the next cycle has IDLE, `result` = 0, `busy` = 0, `done` = 0. A new MUL 99×77 then yields 0x1DC7.
- Back-to-back: ADD accepted in its `done` cycle followed by SUB, then op 11 → each produces exactly one `done` pulse. op 11 gives `result` = 0, `overflow` = 1. Compare against a reference model over 1000 random N=8 operations.
